// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and step-counter sizing.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Counter must hold 0..WIDTH so the step count never aliases.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    assign shifted     = {rem_in[WIDTH-1:0], q_msb};
    assign divisor_ext = {1'b0, divisor};

    // A set rem_in MSB would mean the true shifted value exceeds WIDTH+1 bits and so the divisor.
    assign q_bit   = rem_in[WIDTH] | (shifted >= divisor_ext);
    assign rem_out = q_bit ? (shifted - divisor_ext) : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips RUN and reports on the cycle after accept.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | iterating the restoring step, WIDTH steps
// DONE  | Q/R/div_by_zero presented, held until out_ready
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .q_msb   (q_reg[WIDTH-1]),
        .divisor (div_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign q_next   = {q_reg[WIDTH-2:0], q_bit};
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            div_reg     <= '0;
            rem_reg     <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q_reg   <= A;
                        div_reg <= B;
                        rem_reg <= '0;
                        cnt     <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (B == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            Q           <= '1;
                            R           <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    q_reg   <= q_next;
                    rem_reg <= rem_next;
                    if (cnt == LAST_STEP) begin
                        cnt         <= '0;
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        Q           <= q_next;
                        R           <= rem_next[WIDTH-1:0];
                        div_by_zero <= (div_reg == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for seq_restoring_divider at WIDTH=4 and WIDTH=8.
module tb_seq_restoring_divider;

`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZLAT4 = 1;
    localparam int ZLAT8 = 1;
`else
    localparam int ZLAT4 = 5;
    localparam int ZLAT8 = 9;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv4, ir4, ov4, or4, dz4;
    logic [3:0] a4, b4, q4, r4;
    logic       iv8, ir8, ov8, or8, dz8;
    logic [7:0] a8, b8, q8, r8;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .Q(q4), .R(r4), .div_by_zero(dz4)
    );

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .Q(q8), .R(r8), .div_by_zero(dz8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (!ir4 && n < 20) begin tick(); n++; end
        chk("w4_in_ready_before_accept", 32'(ir4), 1);
        a4 = a; b4 = b; iv4 = 1'b1;
        tick();
        iv4 = 1'b0; a4 = ~a; b4 = ~b;
    endtask

    task automatic wait4(input string tag, input int exp_lat, input logic [3:0] eq,
                         input logic [3:0] er, input logic edz);
        int lat = 1;
        while (!ov4 && lat < 40) begin tick(); lat++; end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, 32'(q4), 32'(eq));
        chk({tag, "_r"}, 32'(r4), 32'(er));
        chk({tag, "_dz"}, 32'(dz4), 32'(edz));
    endtask

    task automatic finish4(input string tag);
        or4 = 1'b1;
        tick();
        chk({tag, "_handoff_ov"}, 32'(ov4), 0);
        chk({tag, "_handoff_ir"}, 32'(ir4), 1);
    endtask

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] eq, er;
        logic edz;
        int lat;
        if (b == 4'd0) begin
            eq = 4'hF; er = a; edz = 1'b1; lat = ZLAT4;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = 5;
        end
        start4(a, b);
        wait4(tag, lat, eq, er, edz);
        finish4(tag);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq, er;
        logic edz;
        int lat, n;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1; lat = ZLAT8;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = 9;
        end
        n = 0;
        while (!ir8 && n < 20) begin tick(); n++; end
        chk({tag, "_ir"}, 32'(ir8), 1);
        a8 = a; b8 = b; iv8 = 1'b1;
        tick();
        iv8 = 1'b0; a8 = $urandom; b8 = $urandom;
        n = 1;
        while (!ov8 && n < 40) begin tick(); n++; end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_q"}, 32'(q8), 32'(eq));
        chk({tag, "_r"}, 32'(r8), 32'(er));
        chk({tag, "_dz"}, 32'(dz8), 32'(edz));
        if (b != 8'd0) begin
            chk({tag, "_inv_qbr"}, 32'(q8) * 32'(b) + 32'(r8), 32'(a));
            chk({tag, "_inv_rltb"}, 32'(r8 < b), 1);
        end
        tick();
        chk({tag, "_handoff_ov"}, 32'(ov8), 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir4), 0);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_q", 32'(q4), 0);
        chk("rst_r", 32'(r4), 0);
        chk("rst_dz", 32'(dz4), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ir4), 1);
        chk("post_rst_in_ready8", 32'(ir8), 1);

        op4("t1_13_3", 4'd13, 4'd3);
        op4("t2_15_15", 4'd15, 4'd15);
        op4("t2_0_5", 4'd0, 4'd5);
        op4("t2_2_9", 4'd2, 4'd9);
        op4("t3_7_0", 4'd7, 4'd0);

        // Backpressure: result must hold and in_valid pulses must be ignored.
        or4 = 1'b0;
        start4(4'd14, 4'd4);
        wait4("t4_bp", 5, 4'd3, 4'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            iv4 = 1'b1; a4 = 4'(i); b4 = 4'd1;
            tick();
            chk("t4_hold_ov", 32'(ov4), 1);
            chk("t4_hold_q", 32'(q4), 3);
            chk("t4_hold_r", 32'(r4), 2);
            chk("t4_hold_ir", 32'(ir4), 0);
        end
        iv4 = 1'b0;
        finish4("t4_bp");
        op4("t4_after", 4'd10, 4'd3);

        // Abort an in-flight division with reset.
        start4(4'd11, 4'd2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_abort_ov", 32'(ov4), 0);
        chk("t5_abort_q", 32'(q4), 0);
        chk("t5_abort_r", 32'(r4), 0);
        chk("t5_abort_dz", 32'(dz4), 0);
        rst = 1'b0;
        #1;
        chk("t5_abort_ir", 32'(ir4), 1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (ov4) seen = 1'b1;
        end
        chk("t5_no_stale_result", 32'(seen), 0);
        op4("t5_9_4", 4'd9, 4'd4);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4("t6_exh", a[3:0], b[3:0]);
            end
        end

        op8("t6_w8_255_1", 8'd255, 8'd1);
        op8("t6_w8_255_255", 8'd255, 8'd255);
        op8("t6_w8_0_0", 8'd0, 8'd0);
        op8("t6_w8_200_0", 8'd200, 8'd0);
        op8("t6_w8_1_255", 8'd1, 8'd255);
        op8("t6_w8_128_7", 8'd128, 8'd7);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            op8("t6_w8_rand", ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
